// File: rtl/rv32e_ex_stage.sv
// RV32E execute stage: EX register, ALU operand/op build, result register.
// Optional distance-1 operand bypass enabled by defining RV32E_EX_FWD_EN.
module rv32e_ex_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_kind,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7b5,
  input  logic [3:0]      in_rs1_addr,
  input  logic [3:0]      in_rs2_addr,
  input  logic [3:0]      in_rd_addr,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_rd_addr,
  output logic            out_rd_we,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_pc,
  output logic            out_br_taken,
  output logic [XLEN-1:0] out_br_target
);

  localparam int unsigned REG_AW = 4;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned KIND_W = 2;
  localparam int unsigned F3_W   = 3;

  localparam logic [KIND_W-1:0] KIND_R     = 2'd0;
  localparam logic [KIND_W-1:0] KIND_I     = 2'd1;
  localparam logic [KIND_W-1:0] KIND_BR    = 2'd2;
  localparam logic [KIND_W-1:0] KIND_AUIPC = 2'd3;

  // EX register
  logic              ex_valid_q,   ex_valid_d;
  logic [KIND_W-1:0] ex_kind_q,    ex_kind_d;
  logic [F3_W-1:0]   ex_funct3_q,  ex_funct3_d;
  logic              ex_funct7b5_q, ex_funct7b5_d;
  logic [REG_AW-1:0] ex_rd_q,      ex_rd_d;
  logic [XLEN-1:0]   ex_rs1_val_q, ex_rs1_val_d;
  logic [XLEN-1:0]   ex_rs2_val_q, ex_rs2_val_d;
  logic [XLEN-1:0]   ex_imm_q,     ex_imm_d;
  logic [XLEN-1:0]   ex_pc_q,      ex_pc_d;
`ifdef RV32E_EX_FWD_EN
  logic [REG_AW-1:0] ex_rs1_addr_q, ex_rs1_addr_d;
  logic [REG_AW-1:0] ex_rs2_addr_q, ex_rs2_addr_d;
`endif

  // Result register
  logic              out_valid_q,     out_valid_d;
  logic [REG_AW-1:0] out_rd_addr_q,   out_rd_addr_d;
  logic              out_rd_we_q,     out_rd_we_d;
  logic [XLEN-1:0]   out_result_q,    out_result_d;
  logic [XLEN-1:0]   out_pc_q,        out_pc_d;
  logic              out_br_taken_q,  out_br_taken_d;
  logic [XLEN-1:0]   out_br_target_q, out_br_target_d;

  logic            ex_adv;
  logic            in_fire;
  logic [XLEN-1:0] rs1_op;
  logic [XLEN-1:0] rs2_op;
  logic [XLEN-1:0] br_target;
  logic            is_branch;
  logic            br_illegal;

  assign ex_adv   = ex_valid_q & (~out_valid_q | out_ready);
  assign in_ready = ~ex_valid_q | ex_adv;
  // A flush kills an acceptance even though in_ready still reads high
  assign in_fire  = in_valid & in_ready & ~flush;

`ifdef RV32E_EX_FWD_EN
  logic fwd_ok;
  assign fwd_ok = out_valid_q & out_rd_we_q;
  assign rs1_op = (fwd_ok && (ex_rs1_addr_q == out_rd_addr_q)) ? out_result_q : ex_rs1_val_q;
  assign rs2_op = (fwd_ok && (ex_rs2_addr_q == out_rd_addr_q)) ? out_result_q : ex_rs2_val_q;
`else
  logic unused_rs_addr;
  assign unused_rs_addr = ^{in_rs1_addr, in_rs2_addr};
  assign rs1_op = ex_rs1_val_q;
  assign rs2_op = ex_rs2_val_q;
`endif

  // ALU op and operand build from the EX register
  always_comb begin
    alu_op = '0;
    alu_a  = rs1_op;
    alu_b  = rs2_op;
    case (ex_kind_q)
      KIND_R: begin
        alu_op = {1'b0, ex_funct7b5_q, ex_funct3_q};
      end
      KIND_I: begin
        alu_op = {1'b0, ex_funct7b5_q & (ex_funct3_q == 3'b101), ex_funct3_q};
        alu_b  = ex_imm_q;
      end
      KIND_BR: begin
        alu_op = {2'b10, ex_funct3_q};
      end
      KIND_AUIPC: begin
        alu_op = OP_W'(0);
        alu_a  = ex_pc_q;
        alu_b  = ex_imm_q;
      end
      default: alu_op = '0;
    endcase
  end

  assign br_target  = ex_pc_q + ex_imm_q;
  assign is_branch  = (ex_kind_q == KIND_BR);
  assign br_illegal = (ex_funct3_q == 3'b010) | (ex_funct3_q == 3'b011);

  // EX register next state
  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_kind_d     = ex_kind_q;
    ex_funct3_d   = ex_funct3_q;
    ex_funct7b5_d = ex_funct7b5_q;
    ex_rd_d       = ex_rd_q;
    ex_rs1_val_d  = ex_rs1_val_q;
    ex_rs2_val_d  = ex_rs2_val_q;
    ex_imm_d      = ex_imm_q;
    ex_pc_d       = ex_pc_q;
`ifdef RV32E_EX_FWD_EN
    ex_rs1_addr_d = ex_rs1_addr_q;
    ex_rs2_addr_d = ex_rs2_addr_q;
`endif
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (in_fire) begin
      ex_valid_d    = 1'b1;
      ex_kind_d     = in_kind;
      ex_funct3_d   = in_funct3;
      ex_funct7b5_d = in_funct7b5;
      ex_rd_d       = in_rd_addr;
      ex_rs1_val_d  = in_rs1_val;
      ex_rs2_val_d  = in_rs2_val;
      ex_imm_d      = in_imm;
      ex_pc_d       = in_pc;
`ifdef RV32E_EX_FWD_EN
      ex_rs1_addr_d = in_rs1_addr;
      ex_rs2_addr_d = in_rs2_addr;
`endif
    end else if (ex_adv) begin
      ex_valid_d = 1'b0;
    end
  end

  // Result register next state
  always_comb begin
    out_valid_d     = out_valid_q;
    out_rd_addr_d   = out_rd_addr_q;
    out_rd_we_d     = out_rd_we_q;
    out_result_d    = out_result_q;
    out_pc_d        = out_pc_q;
    out_br_taken_d  = out_br_taken_q;
    out_br_target_d = out_br_target_q;
    if (ex_adv) begin
      out_rd_addr_d   = ex_rd_q;
      out_rd_we_d     = ~is_branch & (ex_rd_q != REG_AW'(0));
      out_result_d    = alu_result;
      out_pc_d        = ex_pc_q;
      out_br_taken_d  = is_branch & ~br_illegal & alu_result[0];
      out_br_target_d = is_branch ? br_target : '0;
    end
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (ex_adv) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q      <= 1'b0;
      ex_kind_q       <= '0;
      ex_funct3_q     <= '0;
      ex_funct7b5_q   <= 1'b0;
      ex_rd_q         <= '0;
      ex_rs1_val_q    <= '0;
      ex_rs2_val_q    <= '0;
      ex_imm_q        <= '0;
      ex_pc_q         <= '0;
`ifdef RV32E_EX_FWD_EN
      ex_rs1_addr_q   <= '0;
      ex_rs2_addr_q   <= '0;
`endif
      out_valid_q     <= 1'b0;
      out_rd_addr_q   <= '0;
      out_rd_we_q     <= 1'b0;
      out_result_q    <= '0;
      out_pc_q        <= '0;
      out_br_taken_q  <= 1'b0;
      out_br_target_q <= '0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_kind_q       <= ex_kind_d;
      ex_funct3_q     <= ex_funct3_d;
      ex_funct7b5_q   <= ex_funct7b5_d;
      ex_rd_q         <= ex_rd_d;
      ex_rs1_val_q    <= ex_rs1_val_d;
      ex_rs2_val_q    <= ex_rs2_val_d;
      ex_imm_q        <= ex_imm_d;
      ex_pc_q         <= ex_pc_d;
`ifdef RV32E_EX_FWD_EN
      ex_rs1_addr_q   <= ex_rs1_addr_d;
      ex_rs2_addr_q   <= ex_rs2_addr_d;
`endif
      out_valid_q     <= out_valid_d;
      out_rd_addr_q   <= out_rd_addr_d;
      out_rd_we_q     <= out_rd_we_d;
      out_result_q    <= out_result_d;
      out_pc_q        <= out_pc_d;
      out_br_taken_q  <= out_br_taken_d;
      out_br_target_q <= out_br_target_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_rd_addr   = out_rd_addr_q;
  assign out_rd_we     = out_rd_we_q;
  assign out_result    = out_result_q;
  assign out_pc        = out_pc_q;
  assign out_br_taken  = out_br_taken_q;
  assign out_br_target = out_br_target_q;

endmodule

// File: tb/tb_rv32e_ex_stage.sv
// Bench for rv32e_ex_stage: vector table, directed pipeline sequences and a
// randomized stream checked against an instruction-level reference model.
module tb_rv32e_ex_stage;

  typedef struct {
    logic [1:0]  kind;
    logic [2:0]  f3;
    logic        f7;
    logic [3:0]  rs1a;
    logic [3:0]  rs2a;
    logic [3:0]  rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc;
  } instr_t;

  typedef struct {
    instr_t      ins;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        we;
    logic        taken;
    logic [31:0] tgt;
  } vec_t;

  typedef struct {
    logic [3:0]  rd;
    logic        we;
    logic [31:0] res;
    logic        taken;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic        is_br;
  } exp_t;

  logic        clk, rst_n, flush;
  logic        in_valid, in_ready;
  logic [1:0]  in_kind;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [3:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_rs1_val, in_rs2_val, in_imm, in_pc;
  logic [4:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        out_valid, out_ready;
  logic [3:0]  out_rd_addr;
  logic        out_rd_we;
  logic [31:0] out_result, out_pc;
  logic        out_br_taken;
  logic [31:0] out_br_target;

  int n_checks = 0;
  int n_fail   = 0;

  rv32e_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_pc(in_pc),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we), .out_result(out_result),
    .out_pc(out_pc), .out_br_taken(out_br_taken), .out_br_target(out_br_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for rv32e_alu; undefined ops return 1 so masking is observable
  always_comb begin
    alu_result = 32'h1;
    case (alu_op)
      5'b00000: alu_result = alu_a + alu_b;
      5'b01000: alu_result = alu_a - alu_b;
      5'b00001: alu_result = alu_a << alu_b[4:0];
      5'b00010: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      5'b00011: alu_result = {31'b0, alu_a < alu_b};
      5'b00100: alu_result = alu_a ^ alu_b;
      5'b00101: alu_result = alu_a >> alu_b[4:0];
      5'b01101: alu_result = 32'($signed(alu_a) >>> alu_b[4:0]);
      5'b00110: alu_result = alu_a | alu_b;
      5'b00111: alu_result = alu_a & alu_b;
      5'b10000: alu_result = {31'b0, alu_a == alu_b};
      5'b10001: alu_result = {31'b0, alu_a != alu_b};
      5'b10100: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      5'b10101: alu_result = {31'b0, $signed(alu_a) >= $signed(alu_b)};
      5'b10110: alu_result = {31'b0, alu_a < alu_b};
      5'b10111: alu_result = {31'b0, alu_a >= alu_b};
      default:  alu_result = 32'h1;
    endcase
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(input logic [1:0] kind, input logic [2:0] f3, input logic f7,
                                input logic [3:0] rd, input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] imm, input logic [31:0] pc);
    instr_t i;
    i.kind = kind; i.f3 = f3; i.f7 = f7; i.rs1a = 4'd0; i.rs2a = 4'd0; i.rd = rd;
    i.rs1 = rs1; i.rs2 = rs2; i.imm = imm; i.pc = pc;
    return i;
  endfunction

  // Reference: instruction semantics of RV32E ALU ops and branches
  function automatic exp_t model(input instr_t i);
    exp_t m;
    logic [31:0] b;
    logic [4:0] sh;
    m = '{default: '0};
    m.rd = i.rd;
    m.pc = i.pc;
    m.is_br = (i.kind == 2'd2);
    b = (i.kind == 2'd0) ? i.rs2 : i.imm;
    sh = b[4:0];
    if (i.kind == 2'd0 || i.kind == 2'd1) begin
      case (i.f3)
        3'd0: m.res = (i.kind == 2'd0 && i.f7) ? i.rs1 - b : i.rs1 + b;
        3'd1: m.res = i.rs1 << sh;
        3'd2: m.res = ($signed(i.rs1) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: m.res = (i.rs1 < b) ? 32'd1 : 32'd0;
        3'd4: m.res = i.rs1 ^ b;
        3'd5: m.res = i.f7 ? 32'($signed(i.rs1) >>> sh) : i.rs1 >> sh;
        3'd6: m.res = i.rs1 | b;
        default: m.res = i.rs1 & b;
      endcase
      m.we = (i.rd != 4'd0);
    end else if (i.kind == 2'd2) begin
      case (i.f3)
        3'd0: m.taken = (i.rs1 == i.rs2);
        3'd1: m.taken = (i.rs1 != i.rs2);
        3'd4: m.taken = ($signed(i.rs1) < $signed(i.rs2));
        3'd5: m.taken = ($signed(i.rs1) >= $signed(i.rs2));
        3'd6: m.taken = (i.rs1 < i.rs2);
        3'd7: m.taken = (i.rs1 >= i.rs2);
        default: m.taken = 1'b0;
      endcase
      m.tgt = i.pc + i.imm;
    end else begin
      m.res = i.pc + i.imm;
      m.we = (i.rd != 4'd0);
    end
    return m;
  endfunction

  task automatic drive(input instr_t i);
    in_valid = 1'b1;
    in_kind = i.kind; in_funct3 = i.f3; in_funct7b5 = i.f7;
    in_rs1_addr = i.rs1a; in_rs2_addr = i.rs2a; in_rd_addr = i.rd;
    in_rs1_val = i.rs1; in_rs2_val = i.rs2; in_imm = i.imm; in_pc = i.pc;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      flush = 1'b0;
    end
  endtask

  function automatic instr_t rand_instr();
    instr_t i;
    i.kind = 2'($urandom_range(0, 3));
    i.f3 = 3'($urandom_range(0, 7));
    i.f7 = 1'($urandom_range(0, 1));
    if (i.kind == 2'd0 && i.f3 != 3'd0 && i.f3 != 3'd5) i.f7 = 1'b0;
    i.rs1a = 4'($urandom_range(1, 7));
    i.rs2a = 4'($urandom_range(1, 7));
    i.rd = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(8, 15));
    i.rs1 = $urandom();
    i.rs2 = ($urandom_range(0, 3) == 0) ? i.rs1 : $urandom();
    i.imm = $urandom();
    i.pc = $urandom() & 32'hFFFF_FFFC;
    return i;
  endfunction

  vec_t vecs[15];
  instr_t bp[4];
  exp_t exp_q[$];

  initial begin
    instr_t cur, i2;
    exp_t e;
    bit pend, acc;
    int got, first_cyc, last_cyc, acc_n;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(mk(2'd0, 3'd0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0));
    in_valid = 1'b0;

    // Reset: three cycles low, everything reads zero
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_result", out_result, 32'd0);
    check("rst out_rd_we", 32'(out_rd_we), 32'd0);
    check("rst out_rd_addr", 32'(out_rd_addr), 32'd0);
    check("rst out_br_taken", 32'(out_br_taken), 32'd0);
    check("rst out_br_target", out_br_target, 32'd0);
    check("rst out_pc", out_pc, 32'd0);
    check("rst alu_op", 32'(alu_op), 32'd0);
    check("rst alu_a", alu_a, 32'd0);
    check("rst alu_b", alu_b, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst in_ready", 32'(in_ready), 32'd1);

    // Vector table: kind,f3,f7,rd,rs1,rs2,imm,pc | op,a,b,res,we,taken,tgt
    vecs[0]  = '{mk(2'd0, 3'd0, 1'b1, 4'd3, 32'd5, 32'd7, 32'd0, 32'h0),
                 5'b01000, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{mk(2'd2, 3'd4, 1'b0, 4'd0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100),
                 5'b10100, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, 1'b1, 32'h120};
    vecs[2]  = '{mk(2'd1, 3'd0, 1'b1, 4'd5, 32'h10, 32'h99, 32'h3, 32'h0),
                 5'b00000, 32'h10, 32'h3, 32'h13, 1'b1, 1'b0, 32'h0};
    vecs[3]  = '{mk(2'd1, 3'd5, 1'b1, 4'd6, 32'h8000_0000, 32'h0, 32'h404, 32'h0),
                 5'b01101, 32'h8000_0000, 32'h404, 32'hF800_0000, 1'b1, 1'b0, 32'h0};
    vecs[4]  = '{mk(2'd1, 3'd5, 1'b0, 4'd6, 32'h8000_0000, 32'h0, 32'h4, 32'h0),
                 5'b00101, 32'h8000_0000, 32'h4, 32'h0800_0000, 1'b1, 1'b0, 32'h0};
    vecs[5]  = '{mk(2'd0, 3'd3, 1'b0, 4'd7, 32'd1, 32'hFFFF_FFFF, 32'h0, 32'h0),
                 5'b00011, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 32'h0};
    vecs[6]  = '{mk(2'd0, 3'd2, 1'b0, 4'd7, 32'd1, 32'hFFFF_FFFF, 32'h0, 32'h0),
                 5'b00010, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 32'h0};
    vecs[7]  = '{mk(2'd3, 3'd6, 1'b1, 4'd9, 32'hDEAD, 32'hBEEF, 32'h1234_5000, 32'h1000),
                 5'b00000, 32'h1000, 32'h1234_5000, 32'h1234_6000, 1'b1, 1'b0, 32'h0};
    vecs[8]  = '{mk(2'd0, 3'd0, 1'b0, 4'd0, 32'd1, 32'd2, 32'h0, 32'h0),
                 5'b00000, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{mk(2'd2, 3'd2, 1'b0, 4'd4, 32'd0, 32'd0, 32'h8, 32'h200),
                 5'b10010, 32'd0, 32'd0, 32'h0, 1'b0, 1'b0, 32'h208};
    vecs[10] = '{mk(2'd2, 3'd0, 1'b0, 4'd0, 32'd1, 32'd2, 32'hFFFF_FFF0, 32'h300),
                 5'b10000, 32'd1, 32'd2, 32'h0, 1'b0, 1'b0, 32'h2F0};
    vecs[11] = '{mk(2'd2, 3'd7, 1'b0, 4'd0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'hFFFF_FFF0),
                 5'b10111, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, 1'b1, 32'h10};
    vecs[12] = '{mk(2'd0, 3'd1, 1'b0, 4'd8, 32'd1, 32'h23, 32'h0, 32'h0),
                 5'b00001, 32'd1, 32'h23, 32'd8, 1'b1, 1'b0, 32'h0};
    vecs[13] = '{mk(2'd1, 3'd4, 1'b1, 4'd8, 32'hF0, 32'h0, 32'hFF, 32'h0),
                 5'b00100, 32'hF0, 32'hFF, 32'h0F, 1'b1, 1'b0, 32'h0};
    vecs[14] = '{mk(2'd0, 3'd5, 1'b1, 4'd10, 32'hFFFF_FF00, 32'd4, 32'h0, 32'h0),
                 5'b01101, 32'hFFFF_FF00, 32'd4, 32'hFFFF_FFF0, 1'b1, 1'b0, 32'h0};

    out_ready = 1'b1;
    for (int v = 0; v < 15; v++) begin
      @(negedge clk);
      drive(vecs[v].ins);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check($sformatf("vec%0d alu_op", v), 32'(alu_op), 32'(vecs[v].op));
      check($sformatf("vec%0d alu_a", v), alu_a, vecs[v].a);
      check($sformatf("vec%0d alu_b", v), alu_b, vecs[v].b);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d out_valid", v), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d out_rd_addr", v), 32'(out_rd_addr), 32'(vecs[v].ins.rd));
      check($sformatf("vec%0d out_rd_we", v), 32'(out_rd_we), 32'(vecs[v].we));
      check($sformatf("vec%0d out_br_taken", v), 32'(out_br_taken), 32'(vecs[v].taken));
      check($sformatf("vec%0d out_pc", v), out_pc, vecs[v].ins.pc);
      if (vecs[v].ins.kind == 2'd2)
        check($sformatf("vec%0d out_br_target", v), out_br_target, vecs[v].tgt);
      else
        check($sformatf("vec%0d out_result", v), out_result, vecs[v].res);
    end
    idle(2);

    // Backpressure: four ADDIs against a stalled writeback
    for (int k = 0; k < 4; k++)
      bp[k] = mk(2'd1, 3'd0, 1'b0, 4'(k + 1), 32'(k * 16), 32'd0, 32'(k + 1), 32'(k * 4));
    out_ready = 1'b0;
    acc_n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (acc_n < 4) drive(bp[acc_n]); else in_valid = 1'b0;
      #1;
      check($sformatf("bp in_ready c%0d", c), 32'(in_ready), (c < 2) ? 32'd1 : 32'd0);
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) acc_n++;
    end
    @(negedge clk);
    check("bp accepted", 32'(acc_n), 32'd2);
    check("bp held valid", 32'(out_valid), 32'd1);
    check("bp held result", out_result, 32'd1);
    out_ready = 1'b1;
    got = 0; first_cyc = -1; last_cyc = -1;
    for (int c = 0; c < 12 && got < 4; c++) begin
      if (c > 0) @(negedge clk);
      if (acc_n < 4) drive(bp[acc_n]); else in_valid = 1'b0;
      #1;
      if (out_valid) begin
        check($sformatf("bp result %0d", got), out_result, 32'(got * 17 + 1));
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        got++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) acc_n++;
    end
    check("bp retired", 32'(got), 32'd4);
    check("bp no bubble", 32'(last_cyc - first_cyc), 32'd3);
    idle(2);

    // Distance-1 RAW: ADDI x1 = x0+10; ADD x2 = x1+x1 with stale zeros
    cur = mk(2'd1, 3'd0, 1'b0, 4'd1, 32'd0, 32'd0, 32'd10, 32'h40);
    i2 = mk(2'd0, 3'd0, 1'b0, 4'd2, 32'd0, 32'd0, 32'd0, 32'h44);
    i2.rs1a = 4'd1; i2.rs2a = 4'd1;
    @(negedge clk); drive(cur);
    @(posedge clk);
    @(negedge clk); drive(i2);
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    #1;
    check("fwd first result", out_result, 32'd10);
    @(posedge clk);
    @(negedge clk);
    check("fwd rd", 32'(out_rd_addr), 32'd2);
`ifdef RV32E_EX_FWD_EN
    check("fwd result", out_result, 32'd20);
`else
    check("fwd result", out_result, 32'd0);
`endif
    idle(2);

    // Flush with both stages full and a new instruction offered
    out_ready = 1'b0;
    @(negedge clk); drive(bp[0]);
    @(posedge clk);
    @(negedge clk); drive(bp[1]);
    @(posedge clk);
    @(negedge clk);
    drive(bp[2]);
    out_ready = 1'b1;
    flush = 1'b1;
    #1;
    check("flush in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("flush out_valid", 32'(out_valid), 32'd0);
    check("flush ex empty", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("flush quiet c%0d", c), 32'(out_valid), 32'd0);
    end

    // Randomized stream vs reference model
    pend = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!pend) begin
        if ($urandom_range(0, 9) < 7) begin
          cur = rand_instr();
          drive(cur);
          pend = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd unexpected retire", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rnd rd_addr", 32'(out_rd_addr), 32'(e.rd));
          check("rnd rd_we", 32'(out_rd_we), 32'(e.we));
          check("rnd pc", out_pc, e.pc);
          check("rnd br_taken", 32'(out_br_taken), 32'(e.taken));
          if (e.is_br) check("rnd br_target", out_br_target, e.tgt);
          else check("rnd result", out_result, e.res);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(cur));
        pend = 1'b0;
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      #1;
      if (out_valid) begin
        e = exp_q.pop_front();
        check("drain pc", out_pc, e.pc);
        check("drain rd_we", 32'(out_rd_we), 32'(e.we));
        if (!e.is_br) check("drain result", out_result, e.res);
      end
      @(negedge clk);
    end
    check("drain empty", 32'(exp_q.size()), 32'd0);
    idle(2);

    // Asynchronous reset mid-operation drops valids at once
    out_ready = 1'b0;
    @(negedge clk); drive(bp[0]);
    @(posedge clk);
    @(negedge clk); drive(bp[1]);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre-reset out_valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async rst out_valid", 32'(out_valid), 32'd0);
    check("async rst in_ready", 32'(in_ready), 32'd1);
    check("async rst result", out_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32e_ex_stage.md
# rv32e_ex_stage

Execute stage of the RV32E core, directly upstream of `rv32e_alu`. It does three things:
- registers decoded instructions from decode into an EX register;
- builds `alu_op`, `alu_a` and `alu_b` for the combinational ALU;
- captures `alu_result` into a result register that feeds writeback and branch resolution.

Both sides use valid/ready handshakes. Throughput is one instruction per cycle.

## Interface
Parameters:
- `XLEN`, 32, datapath width. Only 32 is supported.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous kill of all in-flight instructions.
- `in_valid` in 1 / `in_ready` out 1: decode handshake.
- `in_kind` in 2: 0 = R-type, 1 = I-type ALU, 2 = branch, 3 = AUIPC.
- `in_funct3` in 3, `in_funct7b5` in 1: instruction function fields.
- `in_rs1_addr`, `in_rs2_addr`, `in_rd_addr` in 4 each: register indices.
- `in_rs1_val`, `in_rs2_val`, `in_imm`, `in_pc` in 32 each: operand values, immediate and PC.
- `alu_op` out 5, `alu_a` out 32, `alu_b` out 32: drive the ALU; combinational from the EX register.
- `alu_result` in 32: combinational return from the ALU.
- `out_valid` out 1 / `out_ready` in 1: writeback handshake.
- `out_rd_addr` out 4, `out_rd_we` out 1, `out_result` out 32, `out_pc` out 32: writeback fields.
- `out_br_taken` out 1, `out_br_target` out 32: branch resolution.

## Operation
Pipeline control:
- `ex_adv = ex_valid & (~out_valid | out_ready)`.
- `in_ready = ~ex_valid | ex_adv`.
- The EX register loads on `in_valid & in_ready`. `ex_valid` clears when `ex_adv` fires and no new instruction is accepted.
- The result register loads on `ex_adv`. `out_valid` clears on `out_ready` when `ex_adv` does not fire.

Op build:
- R-type: `alu_op = {1'b0, funct7b5, funct3}`. This gives SUB = 01000 and SRA = 01101.
- I-type: same encoding, but `funct7b5` is forced to 0 unless `funct3 == 3'b101` (SRAI).
- Branch: `alu_op = {2'b10, funct3}`.
- AUIPC: `alu_op = 5'b00000` (ADD).

Operand select:
- `alu_a` = rs1 for R-type, I-type and branch; `pc` for AUIPC.
- `alu_b` = rs2 for R-type and branch; `imm` for I-type and AUIPC.
- Shift immediates: the ALU uses only `b[4:0]`.

Result capture:
- R-type, I-type, AUIPC: `out_result = alu_result`, `out_rd_we = (rd != 0)`, `out_br_taken = 0`.
- Branch: `out_rd_we = 0`, `out_br_taken = alu_result[0]`, `out_br_target = pc + imm` (mod 2^32, separate adder).
- Branch with `funct3` of 010 or 011 is illegal: not taken, no write, still retired.

Flush:
- Clears `ex_valid` and `out_valid` on the next edge.
- Blocks an acceptance in the same cycle: `in_ready` still reads as computed, but the accepted instruction is dropped.
- Flush has priority over every other event.

## Timing
- Reset: all registers and outputs are 0. `in_ready` = 1 after reset, because `ex_valid` = 0.
- Latency: an instruction accepted at edge N is in EX during cycle N+1. Its result is captured at edge N+1 if the output register is free or draining. `out_valid` is high from cycle N+2.
- Backpressure: when `out_ready` = 0, both registers hold. `in_ready` drops when EX is full. No data changes while a valid is held.
- Simultaneous drain and fill: output handshake, `ex_adv` and input acceptance may all fire in one cycle with no bubble.
- Reset mid-operation: all valids drop immediately (asynchronous). No partial writeback.

## Configuration
- Macro: `RV32E_EX_FWD_EN`.
- With the macro: if an operand address matches `out_rd_addr`, `out_rd_we` is 1 and `out_valid` is 1, the operand value is replaced by `out_result`. Forwarding is done on the combinational ALU inputs, so distance-1 RAW needs no stall. Decode only has to guarantee the regfile write-before-read for distances of 2 or more.
- Without the macro: no bypass. Decode must interlock every RAW hazard.

## Test plan
- Reset: hold `rst_n` = 0 for 3 cycles → all outputs 0, then `in_ready` = 1.
- Arithmetic: R-type SUB with rs1 = 5, rs2 = 7, rd = 3 → `alu_op` = 01000; two cycles after acceptance `out_result` = 0xFFFFFFFE and `out_rd_we` = 1.
- Branch: BLT at pc 0x100, imm 0x20, rs1 = 0xFFFFFFFF, rs2 = 1 → `out_br_taken` = 1, `out_br_target` = 0x120, `out_rd_we` = 0.
- Backpressure: stream 4 ADDIs with `out_ready` = 0 → `in_ready` drops after 2 acceptances. Release `out_ready` → 4 results in order, one per cycle.
- Forwarding (`RV32E_EX_FWD_EN`): ADDI x1 = x0 + 10, then ADD x2 = x1 + x1 with stale rs values of 0 → `out_result` = 20. Without the macro → 0.
- Flush: assert `flush` with both stages valid and `in_valid` = 1 → next cycle `out_valid` = 0 and `ex_valid` = 0, and no result appears.
